fft_bfly_seq: RTL and testbench

- Radix-2 DIT butterfly sequencer. The FFT ALU is the responder; this block is the initiator that drives it.
- Accepts one butterfly (x0, x1, twiddle w, all complex Q1.15) through a valid/ready handshake.
- Issues ten ALU operations, one per cycle, on the shared combinational ALU port and gathers the results.
- Returns y0 = x0 + w·x1 and y1 = x0 − w·x1 through a valid/ready handshake.

---
 rtl/fft_bfly_seq.sv | 197 +++++++++++++++++++
 tb/tb_fft_bfly_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_seq.sv
// Radix-2 DIT butterfly sequencer: drives a shared combinational FFT ALU
// through ten single-cycle operations to form y0 = x0 + w*x1, y1 = x0 - w*x1.
// Build option: define FFT_BFLY_SCALE_EN to halve the final sums (block
// scaling per stage) instead of saturating them.
//
// state | meaning
// IDLE  | waiting for operands, in_ready_o high
// MUL0  | p0 = x1_re * w_re
// MUL1  | p1 = x1_im * w_im
// MUL2  | p2 = x1_re * w_im
// MUL3  | p3 = x1_im * w_re
// TRE   | t_re = p0 - p1
// TIM   | t_im = p2 + p3
// Y0R   | y0_re = x0_re + t_re
// Y0I   | y0_im = x0_im + t_im
// Y1R   | y1_re = x0_re - t_re
// Y1I   | y1_im = x0_im - t_im
// OUT   | results valid, waiting for out_ready_i

`ifndef ALUMODE_IDLE
`define ALUMODE_IDLE     5'd0
`endif
`ifndef ALUMODE_A_ADD_B
`define ALUMODE_A_ADD_B  5'd1
`endif
`ifndef ALUMODE_A_SUB_B
`define ALUMODE_A_SUB_B  5'd2
`endif
`ifndef ALUMODE_A_MULT_B
`define ALUMODE_A_MULT_B 5'd3
`endif

module fft_bfly_seq #(
    parameter int Q_FRAC = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic signed [15:0] x0_re_i,
    input  logic signed [15:0] x0_im_i,
    input  logic signed [15:0] x1_re_i,
    input  logic signed [15:0] x1_im_i,
    input  logic signed [15:0] w_re_i,
    input  logic signed [15:0] w_im_i,
    output logic [4:0]         alu_mode_o,
    output logic signed [15:0] op_a_o,
    output logic signed [15:0] op_b_o,
    output logic signed [15:0] op_c_o,
    input  logic signed [31:0] alu_res_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic signed [15:0] y0_re_o,
    output logic signed [15:0] y0_im_o,
    output logic signed [15:0] y1_re_o,
    output logic signed [15:0] y1_im_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_TRE, S_TIM,
        S_Y0R, S_Y0I, S_Y1R, S_Y1I, S_OUT
    } state_t;

    state_t state_q, state_d;
    logic signed [15:0] x0_re_q, x0_im_q, x1_re_q, x1_im_q, w_re_q, w_im_q;
    logic signed [15:0] x0_re_d, x0_im_d, x1_re_d, x1_im_d, w_re_d, w_im_d;
    logic signed [15:0] p0_q, p1_q, p2_q, p3_q, t_re_q, t_im_q;
    logic signed [15:0] p0_d, p1_d, p2_d, p3_d, t_re_d, t_im_d;
    logic signed [15:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
    logic signed [15:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;
    logic [4:0]         mode_q, mode_d;
    logic signed [15:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic               out_valid_q, out_valid_d;

    logic signed [31:0] prod_shift;
    logic signed [15:0] prod_sat;
    logic signed [16:0] sum17;
    logic signed [15:0] sum_sat;
    logic signed [15:0] y_val;

    // Result conditioning: products scaled by Q_FRAC, sums kept to 17 bits.
    always_comb begin
        prod_shift = alu_res_i >>> Q_FRAC;
        if (prod_shift > 32'sd32767)
            prod_sat = 16'sh7fff;
        else if (prod_shift < -32'sd32768)
            prod_sat = 16'sh8000;
        else
            prod_sat = prod_shift[15:0];
        sum17 = alu_res_i[16:0];
        if (sum17 > 17'sd32767)
            sum_sat = 16'sh7fff;
        else if (sum17 < -17'sd32768)
            sum_sat = 16'sh8000;
        else
            sum_sat = sum17[15:0];
`ifdef FFT_BFLY_SCALE_EN
        y_val = sum17[16:1];
`else
        y_val = sum_sat;
`endif
    end

    // Next-state logic and result capture, one ALU step per state.
    always_comb begin
        state_d = state_q;
        x0_re_d = x0_re_q;  x0_im_d = x0_im_q;
        x1_re_d = x1_re_q;  x1_im_d = x1_im_q;
        w_re_d  = w_re_q;   w_im_d  = w_im_q;
        p0_d = p0_q;  p1_d = p1_q;  p2_d = p2_q;  p3_d = p3_q;
        t_re_d = t_re_q;  t_im_d = t_im_q;
        y0_re_d = y0_re_q;  y0_im_d = y0_im_q;
        y1_re_d = y1_re_q;  y1_im_d = y1_im_q;
        case (state_q)
            S_IDLE: if (in_valid_i) begin
                x0_re_d = x0_re_i;  x0_im_d = x0_im_i;
                x1_re_d = x1_re_i;  x1_im_d = x1_im_i;
                w_re_d  = w_re_i;   w_im_d  = w_im_i;
                state_d = S_MUL0;
            end
            S_MUL0: begin p0_d = prod_sat;   state_d = S_MUL1; end
            S_MUL1: begin p1_d = prod_sat;   state_d = S_MUL2; end
            S_MUL2: begin p2_d = prod_sat;   state_d = S_MUL3; end
            S_MUL3: begin p3_d = prod_sat;   state_d = S_TRE;  end
            S_TRE:  begin t_re_d = sum_sat;  state_d = S_TIM;  end
            S_TIM:  begin t_im_d = sum_sat;  state_d = S_Y0R;  end
            S_Y0R:  begin y0_re_d = y_val;   state_d = S_Y0I;  end
            S_Y0I:  begin y0_im_d = y_val;   state_d = S_Y1R;  end
            S_Y1R:  begin y1_re_d = y_val;   state_d = S_Y1I;  end
            S_Y1I:  begin y1_im_d = y_val;   state_d = S_OUT;  end
            S_OUT:  if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU drive decoded from the next state so the registered mode/operands
    // line up with the state in which the ALU result is captured. Operands
    // come from the _d values so a result captured this cycle is usable next.
    always_comb begin
        mode_d = `ALUMODE_IDLE;
        op_a_d = '0;
        op_b_d = '0;
        case (state_d)
            S_MUL0: begin mode_d = `ALUMODE_A_MULT_B; op_a_d = x1_re_d; op_b_d = w_re_d; end
            S_MUL1: begin mode_d = `ALUMODE_A_MULT_B; op_a_d = x1_im_d; op_b_d = w_im_d; end
            S_MUL2: begin mode_d = `ALUMODE_A_MULT_B; op_a_d = x1_re_d; op_b_d = w_im_d; end
            S_MUL3: begin mode_d = `ALUMODE_A_MULT_B; op_a_d = x1_im_d; op_b_d = w_re_d; end
            S_TRE:  begin mode_d = `ALUMODE_A_SUB_B;  op_a_d = p0_d;    op_b_d = p1_d;   end
            S_TIM:  begin mode_d = `ALUMODE_A_ADD_B;  op_a_d = p2_d;    op_b_d = p3_d;   end
            S_Y0R:  begin mode_d = `ALUMODE_A_ADD_B;  op_a_d = x0_re_d; op_b_d = t_re_d; end
            S_Y0I:  begin mode_d = `ALUMODE_A_ADD_B;  op_a_d = x0_im_d; op_b_d = t_im_d; end
            S_Y1R:  begin mode_d = `ALUMODE_A_SUB_B;  op_a_d = x0_re_d; op_b_d = t_re_d; end
            S_Y1I:  begin mode_d = `ALUMODE_A_SUB_B;  op_a_d = x0_im_d; op_b_d = t_im_d; end
            default: ;
        endcase
        out_valid_d = (state_d == S_OUT);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x0_re_q <= '0;  x0_im_q <= '0;  x1_re_q <= '0;  x1_im_q <= '0;
            w_re_q  <= '0;  w_im_q  <= '0;
            p0_q <= '0;  p1_q <= '0;  p2_q <= '0;  p3_q <= '0;
            t_re_q <= '0;  t_im_q <= '0;
            y0_re_q <= '0;  y0_im_q <= '0;  y1_re_q <= '0;  y1_im_q <= '0;
            mode_q <= `ALUMODE_IDLE;
            op_a_q <= '0;  op_b_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_re_q <= x0_re_d;  x0_im_q <= x0_im_d;
            x1_re_q <= x1_re_d;  x1_im_q <= x1_im_d;
            w_re_q  <= w_re_d;   w_im_q  <= w_im_d;
            p0_q <= p0_d;  p1_q <= p1_d;  p2_q <= p2_d;  p3_q <= p3_d;
            t_re_q <= t_re_d;  t_im_q <= t_im_d;
            y0_re_q <= y0_re_d;  y0_im_q <= y0_im_d;
            y1_re_q <= y1_re_d;  y1_im_q <= y1_im_d;
            mode_q <= mode_d;
            op_a_q <= op_a_d;  op_b_q <= op_b_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign alu_mode_o  = mode_q;
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign op_c_o      = '0;
    assign out_valid_o = out_valid_q;
    assign y0_re_o     = y0_re_q;
    assign y0_im_o     = y0_im_q;
    assign y1_re_o     = y1_re_q;
    assign y1_im_o     = y1_im_q;

endmodule

// File: tb/tb_fft_bfly_seq.sv
// Directed bench for fft_bfly_seq with a behavioural model of the FFT ALU.
`ifndef ALUMODE_IDLE
`define ALUMODE_IDLE     5'd0
`endif
`ifndef ALUMODE_A_ADD_B
`define ALUMODE_A_ADD_B  5'd1
`endif
`ifndef ALUMODE_A_SUB_B
`define ALUMODE_A_SUB_B  5'd2
`endif
`ifndef ALUMODE_A_MULT_B
`define ALUMODE_A_MULT_B 5'd3
`endif

module tb_fft_bfly_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid_i;
    logic               in_ready_o;
    logic signed [15:0] x0_re_i, x0_im_i, x1_re_i, x1_im_i, w_re_i, w_im_i;
    logic [4:0]         alu_mode_o;
    logic signed [15:0] op_a_o, op_b_o, op_c_o;
    logic signed [31:0] alu_res_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic signed [15:0] y0_re_o, y0_im_o, y1_re_o, y1_im_o;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic signed [15:0] x0r, x0i, x1r, x1i, wr, wi;
        logic signed [15:0] y0r, y0i, y1r, y1i;
    } vec_t;

    vec_t       vecs[5];
    logic [4:0] mode_seen[10];
    logic       opc_bad;

    fft_bfly_seq dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .x0_re_i(x0_re_i), .x0_im_i(x0_im_i), .x1_re_i(x1_re_i), .x1_im_i(x1_im_i),
        .w_re_i(w_re_i), .w_im_i(w_im_i),
        .alu_mode_o(alu_mode_o), .op_a_o(op_a_o), .op_b_o(op_b_o), .op_c_o(op_c_o),
        .alu_res_i(alu_res_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .y0_re_o(y0_re_o), .y0_im_o(y0_im_o), .y1_re_o(y1_re_o), .y1_im_o(y1_im_o)
    );

    always #5 clk = ~clk;

    // Combinational ALU responder.
    always_comb begin
        alu_res_i = '0;
        case (alu_mode_o)
            `ALUMODE_A_MULT_B: alu_res_i = 32'(op_a_o) * 32'(op_b_o);
            `ALUMODE_A_ADD_B:  alu_res_i = 32'(op_a_o) + 32'(op_b_o);
            `ALUMODE_A_SUB_B:  alu_res_i = 32'(op_a_o) - 32'(op_b_o);
            default:           alu_res_i = '0;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int x0r, x0i, x1r, x1i, wr, wi,
                                input int y0r, y0i, y1r, y1i);
        vec_t v;
        v.x0r = 16'(x0r); v.x0i = 16'(x0i); v.x1r = 16'(x1r); v.x1i = 16'(x1i);
        v.wr  = 16'(wr);  v.wi  = 16'(wi);
        v.y0r = 16'(y0r); v.y0i = 16'(y0i); v.y1r = 16'(y1r); v.y1i = 16'(y1i);
        return v;
    endfunction

    function automatic int exp_mode(input int i);
        case (i)
            0, 1, 2, 3: return int'(`ALUMODE_A_MULT_B);
            4, 8, 9:    return int'(`ALUMODE_A_SUB_B);
            default:    return int'(`ALUMODE_A_ADD_B);
        endcase
    endfunction

    task automatic drive(input vec_t v);
        x0_re_i = v.x0r; x0_im_i = v.x0i; x1_re_i = v.x1r; x1_im_i = v.x1i;
        w_re_i  = v.wr;  w_im_i  = v.wi;
    endtask

    task automatic wait_idle(input string tag);
        int cnt = 0;
        @(negedge clk);
        while (!in_ready_o && cnt < 50) begin @(negedge clk); cnt++; end
        if (cnt >= 50) chk({tag, "_idle_timeout"}, 0, 1);
    endtask

    // Called just after the accepting edge; returns at the negedge of the
    // first OUT cycle with latency, ALU modes and results checked.
    task automatic collect(input vec_t v, input string tag);
        int cnt = 1;
        @(negedge clk);
        while (!out_valid_o && cnt < 40) begin
            if (cnt <= 10) mode_seen[cnt-1] = alu_mode_o;
            if (op_c_o != 16'sd0) opc_bad = 1'b1;
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 11);
        chk({tag, "_out_mode_idle"}, int'(alu_mode_o), int'(`ALUMODE_IDLE));
        chk({tag, "_y0_re"}, int'(y0_re_o), int'(v.y0r));
        chk({tag, "_y0_im"}, int'(y0_im_o), int'(v.y0i));
        chk({tag, "_y1_re"}, int'(y1_re_o), int'(v.y1r));
        chk({tag, "_y1_im"}, int'(y1_im_o), int'(v.y1i));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        out_ready_i = 1'b1;
        wait_idle(tag);
        drive(v);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        collect(v, tag);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc_cyc[3];
        int sel[3];
        int aidx, oidx;
        logic acc;

`ifdef FFT_BFLY_SCALE_EN
        vecs[0] = mk(1000, 0, 2000, 0, 32767, 0,          1499, 0, -500, 0);
        vecs[1] = mk(0, 0, 100, 200, 0, -32768,           100, -50, -100, 50);
        vecs[2] = mk(32767, 0, -32768, 0, -32768, 0,      32767, 0, 0, 0);
        vecs[3] = mk(-500, 300, 1000, -2000, 23170, -23170, -604, -912, 103, 1211);
        vecs[4] = mk(-32768, 0, 32767, 0, 32767, 0,       -1, 0, -32767, 0);
`else
        vecs[0] = mk(1000, 0, 2000, 0, 32767, 0,          2999, 0, -999, 0);
        vecs[1] = mk(0, 0, 100, 200, 0, -32768,           200, -100, -200, 100);
        vecs[2] = mk(32767, 0, -32768, 0, -32768, 0,      32767, 0, 0, 0);
        vecs[3] = mk(-500, 300, 1000, -2000, 23170, -23170, -1207, -1823, 207, 2423);
        vecs[4] = mk(-32768, 0, 32767, 0, 32767, 0,       -2, 0, -32768, 0);
`endif
        opc_bad = 1'b0;
        rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready_o), 1);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_mode", int'(alu_mode_o), int'(`ALUMODE_IDLE));
        chk("rst_op_a", int'(op_a_o), 0);
        chk("rst_y0_re", int'(y0_re_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven butterflies.
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 1)
                for (int k = 0; k < 10; k++)
                    chk($sformatf("mode_step%0d", k), int'(mode_seen[k]), exp_mode(k));
        end
        chk("op_c_zero", int'(opc_bad), 0);

        // Backpressure with new data waiting.
        out_ready_i = 1'b0;
        wait_idle("bp");
        drive(vecs[0]);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        drive(vecs[3]);
        collect(vecs[0], "bp_a");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d_ready", i), int'(in_ready_o), 0);
            chk($sformatf("bp_hold%0d_valid", i), int'(out_valid_o), 1);
            chk($sformatf("bp_hold%0d_y0", i), int'(y0_re_o), int'(vecs[0].y0r));
            chk($sformatf("bp_hold%0d_y1", i), int'(y1_re_o), int'(vecs[0].y1r));
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_ready", int'(in_ready_o), 1);
        chk("bp_after_valid", int'(out_valid_o), 0);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        collect(vecs[3], "bp_b");
        @(posedge clk); #1;

        // Reset while in MUL2.
        wait_idle("rstmid");
        drive(vecs[2]);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_mul2_mode", int'(alu_mode_o), int'(`ALUMODE_A_MULT_B));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_mode", int'(alu_mode_o), int'(`ALUMODE_IDLE));
        chk("rstmid_out_valid", int'(out_valid_o), 0);
        chk("rstmid_in_ready", int'(in_ready_o), 1);
        chk("rstmid_op_b", int'(op_b_o), 0);
        run_vec(vecs[0], "after_rst");

        // Back-to-back, three butterflies.
        sel[0] = 0; sel[1] = 3; sel[2] = 4;
        aidx = 0; oidx = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
        out_ready_i = 1'b1;
        drive(vecs[sel[0]]);
        in_valid_i = 1'b1;
        for (int c = 0; c < 150 && oidx < 3; c++) begin
            @(negedge clk);
            if (out_valid_o) begin
                chk($sformatf("b2b%0d_y0_re", oidx), int'(y0_re_o), int'(vecs[sel[oidx]].y0r));
                chk($sformatf("b2b%0d_y0_im", oidx), int'(y0_im_o), int'(vecs[sel[oidx]].y0i));
                chk($sformatf("b2b%0d_y1_re", oidx), int'(y1_re_o), int'(vecs[sel[oidx]].y1r));
                chk($sformatf("b2b%0d_y1_im", oidx), int'(y1_im_o), int'(vecs[sel[oidx]].y1i));
                oidx++;
            end
            acc = in_valid_i && in_ready_o;
            if (acc && aidx < 3) begin
                acc_cyc[aidx] = c;
                aidx++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (aidx < 3) drive(vecs[sel[aidx]]);
                else in_valid_i = 1'b0;
            end
        end
        in_valid_i = 1'b0;
        chk("b2b_outputs", oidx, 3);
        chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 12);
        chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
